// File: rtl/usb_tx_encoder.sv
// Full-speed USB transmit encoder: SYNC, LSB-first serialisation, bit stuffing, NRZI and EOP.
// Optional abort sequence enabled with `define USB_TX_ABORT_EN (adds the tx_abort input).
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
`ifdef USB_TX_ABORT_EN
    input  logic       tx_abort,
`endif
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_underrun
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_DATA    = 3'd2,
        ST_STUFF   = 3'd3,
        ST_EOP_SE0 = 3'd4,
        ST_EOP_J   = 3'd5
`ifdef USB_TX_ABORT_EN
        ,ST_ABORT  = 3'd6
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    ones_q, ones_d;
    logic [7:0]    buf_data_q, buf_data_d;
    logic          buf_last_q, buf_last_d;
    logic          buf_full_q, buf_full_d;
    logic          last_acc_q, last_acc_d;
    logic          cur_last_q, cur_last_d;
    logic          line_j_q, line_j_d;
    logic          dp_q, dp_d;
    logic          dm_q, dm_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic          underrun_q, underrun_d;
`ifdef USB_TX_ABORT_EN
    logic          abort_req_q, abort_req_d;
`endif

    logic          boundary_s;
    logic          accept_s;
    logic          tx_ready_s;
    logic          send_s;
    logic          send_val_s;
    logic          se0_s;
    logic          load_s;
    logic          nxt_line_s;
    logic [7:0]    ld_data_s;
    logic          ld_last_s;

    // NRZI: a 1 holds the line state, a 0 toggles between J and K
    function automatic logic nrzi_next(input logic line_j, input logic bit_val);
        return bit_val ? line_j : ~line_j;
    endfunction

    // Ready only while the holding buffer can take a byte of the current packet
    always_comb begin
        tx_ready_s = ~buf_full_q & ~last_acc_q &
                     (state_q != ST_EOP_SE0) & (state_q != ST_EOP_J);
`ifdef USB_TX_ABORT_EN
        tx_ready_s = tx_ready_s & (state_q != ST_ABORT);
`endif
    end

    assign boundary_s = (timer_q == TMAX);
    assign accept_s   = tx_valid & tx_ready_s;

    // Next-state, buffer and line-drive computation
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ones_d     = ones_q;
        buf_data_d = buf_data_q;
        buf_last_d = buf_last_q;
        buf_full_d = buf_full_q;
        last_acc_d = last_acc_q;
        cur_last_d = cur_last_q;
        line_j_d   = line_j_q;
        dp_d       = dp_q;
        dm_d       = dm_q;
        active_d   = active_q;
        done_d     = 1'b0;
        underrun_d = 1'b0;
        send_s     = 1'b0;
        send_val_s = 1'b0;
        se0_s      = 1'b0;
        load_s     = 1'b0;
        nxt_line_s = line_j_q;
        ld_data_s  = buf_data_q;
        ld_last_s  = buf_last_q;

        if (boundary_s) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        if (accept_s) begin
            buf_data_d = tx_data;
            buf_last_d = tx_last;
            buf_full_d = 1'b1;
            last_acc_d = last_acc_q | tx_last;
        end else begin
            buf_full_d = buf_full_q;
        end

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (accept_s) begin
                    state_d    = ST_SYNC;
                    bit_cnt_d  = 3'd0;
                    active_d   = 1'b1;
                    send_s     = 1'b1;
                    send_val_s = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (boundary_s && (bit_cnt_q != 3'd7)) begin
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    send_s     = 1'b1;
                    send_val_s = (bit_cnt_q == 3'd6);
                end else if (boundary_s) begin
                    load_s = 1'b1;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_DATA, ST_STUFF: begin
                if (!boundary_s) begin
                    state_d = state_q;
                end else if (ones_q == 3'd6) begin
                    state_d    = ST_STUFF;
                    send_s     = 1'b1;
                    send_val_s = 1'b0;
                end else if (bit_cnt_q != 3'd7) begin
                    state_d    = ST_DATA;
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    shift_d    = {1'b0, shift_q[7:1]};
                    send_s     = 1'b1;
                    send_val_s = shift_q[1];
                end else if (cur_last_q) begin
                    state_d   = ST_EOP_SE0;
                    bit_cnt_d = 3'd0;
                    se0_s     = 1'b1;
                end else begin
                    load_s = 1'b1;
                end
            end
            ST_EOP_SE0: begin
                if (boundary_s && (bit_cnt_q == 3'd1)) begin
                    state_d  = ST_EOP_J;
                    line_j_d = 1'b1;
                    dp_d     = 1'b1;
                    dm_d     = 1'b0;
                end else if (boundary_s) begin
                    bit_cnt_d = 3'd1;
                end else begin
                    state_d = ST_EOP_SE0;
                end
            end
            ST_EOP_J: begin
                if (boundary_s) begin
                    state_d    = ST_IDLE;
                    active_d   = 1'b0;
                    done_d     = 1'b1;
                    last_acc_d = 1'b0;
                end else begin
                    state_d = ST_EOP_J;
                end
            end
`ifdef USB_TX_ABORT_EN
            ST_ABORT: begin
                if (boundary_s && (bit_cnt_q == 3'd6)) begin
                    state_d   = ST_EOP_SE0;
                    bit_cnt_d = 3'd0;
                    se0_s     = 1'b1;
                end else if (boundary_s) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end else begin
                    state_d = ST_ABORT;
                end
            end
`endif
            default: begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
                line_j_d = 1'b1;
                dp_d     = 1'b1;
                dm_d     = 1'b0;
            end
        endcase

        // Byte boundary: a byte arriving in this very cycle is taken straight from the port
        if (load_s && (buf_full_q || accept_s)) begin
            if (buf_full_q) begin
                ld_data_s  = buf_data_q;
                ld_last_s  = buf_last_q;
                buf_full_d = accept_s;
            end else begin
                ld_data_s  = tx_data;
                ld_last_s  = tx_last;
                buf_full_d = 1'b0;
            end
            state_d    = ST_DATA;
            shift_d    = ld_data_s;
            cur_last_d = ld_last_s;
            bit_cnt_d  = 3'd0;
            send_s     = 1'b1;
            send_val_s = ld_data_s[0];
        end else if (load_s) begin
            underrun_d = 1'b1;
            state_d    = ST_EOP_SE0;
            bit_cnt_d  = 3'd0;
            buf_full_d = 1'b0;
            se0_s      = 1'b1;
        end else begin
            cur_last_d = cur_last_d;
        end

        if (send_s) begin
            nxt_line_s = nrzi_next(line_j_q, send_val_s);
            line_j_d   = nxt_line_s;
            dp_d       = nxt_line_s;
            dm_d       = ~nxt_line_s;
            ones_d     = send_val_s ? (ones_q + 3'd1) : 3'd0;
        end else if (se0_s) begin
            dp_d = 1'b0;
            dm_d = 1'b0;
        end else begin
            ones_d = ones_d;
        end

`ifdef USB_TX_ABORT_EN
        abort_req_d = abort_req_q;
        if ((state_q == ST_SYNC) || (state_q == ST_DATA) || (state_q == ST_STUFF)) begin
            if (boundary_s && (abort_req_q || tx_abort)) begin
                // Hold the line (NRZI ones) with stuffing suppressed, then EOP
                state_d     = ST_ABORT;
                bit_cnt_d   = 3'd0;
                line_j_d    = line_j_q;
                dp_d        = line_j_q;
                dm_d        = ~line_j_q;
                ones_d      = 3'd0;
                buf_full_d  = 1'b0;
                underrun_d  = 1'b0;
                abort_req_d = 1'b0;
            end else if (tx_abort) begin
                abort_req_d = 1'b1;
            end else begin
                abort_req_d = abort_req_q;
            end
        end else begin
            abort_req_d = 1'b0;
        end
`endif
    end

    // State and output registers; reset returns the lines to idle J at once
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            ones_q      <= 3'd0;
            buf_data_q  <= 8'h00;
            buf_last_q  <= 1'b0;
            buf_full_q  <= 1'b0;
            last_acc_q  <= 1'b0;
            cur_last_q  <= 1'b0;
            line_j_q    <= 1'b1;
            dp_q        <= 1'b1;
            dm_q        <= 1'b0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef USB_TX_ABORT_EN
            abort_req_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ones_q      <= ones_d;
            buf_data_q  <= buf_data_d;
            buf_last_q  <= buf_last_d;
            buf_full_q  <= buf_full_d;
            last_acc_q  <= last_acc_d;
            cur_last_q  <= cur_last_d;
            line_j_q    <= line_j_d;
            dp_q        <= dp_d;
            dm_q        <= dm_d;
            active_q    <= active_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
`ifdef USB_TX_ABORT_EN
            abort_req_q <= abort_req_d;
`endif
        end
    end

    assign tx_ready    = tx_ready_s;
    assign d_plus      = dp_q;
    assign d_minus     = dm_q;
    assign tx_active   = active_q;
    assign tx_done     = done_q;
    assign tx_underrun = underrun_q;

endmodule
